// File: rtl/serv_fetch_pkg.sv
// Shared definitions for the SERV fetch aligner: FSM state encoding and the
// compressed-instruction test applied to a 16-bit instruction parcel.
package serv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    RESP     = 2'd3
  } state_t;

  // A parcel is a full 32-bit instruction only when both low bits are set.
  localparam logic [1:0] C_MASK = 2'b11;

  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw & {14'h0, C_MASK}) != {14'h0, C_MASK};
  endfunction

endpackage

// File: rtl/serv_fetch_hwbuf.sv
// One-entry halfword buffer: upper half of the last bus word read, its word tag,
// and a valid bit. FETCH_HWBUF_EN enables hits; without it valid stays 0.
module serv_fetch_hwbuf #(
  parameter int TAG_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [15:0]      load_data,
  input  logic [TAG_W-1:0] load_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic [15:0]      data,
  output logic             hit
);

  logic [TAG_W-1:0] tag;
  logic             valid;

  // Data is loaded unconditionally so it can stage the low parcel of a
  // straddling fetch even when a flush or a disabled build keeps valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      tag  <= '0;
    end else if (load) begin
      data <= load_data;
      tag  <= load_tag;
    end
  end

`ifdef FETCH_HWBUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign valid        = 1'b0;
`endif

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/serv_fetch_align.sv
// Fetch sequencer: returns one raw (possibly word-straddling) instruction per
// halfword-aligned PC request. Optional hit paths via FETCH_HWBUF_EN.
module serv_fetch_align
  import serv_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_cpu_adr,
  input  logic              i_cpu_cyc,
  output logic [31:0]       o_cpu_rdt,
  output logic              o_cpu_ack,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic              o_wb_cyc,
  input  logic [31:0]       i_wb_rdt,
  input  logic              i_wb_ack
);

  localparam int WW = ADDR_W - 2;
  localparam logic [WW-1:0] WORD_ONE = {{(WW-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W-1:0] wb_adr, wb_adr_n;
  logic [31:0]       rdt, rdt_n;

  logic              buf_load;
  logic [15:0]       buf_data;
  logic              buf_hit;

  logic [WW-1:0]     cpu_word, cpu_word_inc, wb_word, wb_word_inc;
  logic              hi_half;
  logic              unused;

  assign cpu_word     = i_cpu_adr[ADDR_W-1:2];
  assign hi_half      = i_cpu_adr[1];
  assign unused       = i_cpu_adr[0];
  assign wb_word      = wb_adr[ADDR_W-1:2];
  // Word increments wrap naturally at the top of the address space.
  assign cpu_word_inc = cpu_word + WORD_ONE;
  assign wb_word_inc  = wb_word + WORD_ONE;

  serv_fetch_hwbuf #(.TAG_W(WW)) u_hwbuf (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (i_flush),
    .load       (buf_load),
    .load_data  (i_wb_rdt[31:16]),
    .load_tag   (wb_word),
    .lookup_tag (cpu_word),
    .data       (buf_data),
    .hit        (buf_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      wb_adr <= '0;
      rdt    <= '0;
    end else begin
      state  <= state_n;
      wb_adr <= wb_adr_n;
      rdt    <= rdt_n;
    end
  end

  always_comb begin
    state_n  = state;
    wb_adr_n = wb_adr;
    rdt_n    = rdt;
    buf_load = 1'b0;
    case (state)
      IDLE: if (i_cpu_cyc) begin
        if (hi_half && buf_hit && is_compressed(buf_data)) begin
          state_n = RESP;
          rdt_n   = {16'h0, buf_data};
        end else if (hi_half && buf_hit) begin
          state_n  = FETCH_HI;
          wb_adr_n = {cpu_word_inc, 2'b00};
        end else begin
          state_n  = FETCH_LO;
          wb_adr_n = {cpu_word, 2'b00};
        end
      end
      FETCH_LO: if (i_wb_ack) begin
        buf_load = 1'b1;
        if (!hi_half) begin
          state_n = RESP;
          rdt_n   = is_compressed(i_wb_rdt[15:0]) ? {16'h0, i_wb_rdt[15:0]} : i_wb_rdt;
        end else if (is_compressed(i_wb_rdt[31:16])) begin
          state_n = RESP;
          rdt_n   = {16'h0, i_wb_rdt[31:16]};
        end else begin
          state_n  = FETCH_HI;
          wb_adr_n = {wb_word_inc, 2'b00};
        end
      end
      // Low parcel of the straddle sits in the buffer (hit or just loaded).
      FETCH_HI: if (i_wb_ack) begin
        buf_load = 1'b1;
        rdt_n    = {i_wb_rdt[15:0], buf_data};
        state_n  = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign o_cpu_rdt = rdt;
  assign o_cpu_ack = (state == RESP);
  assign o_wb_adr  = wb_adr;
  assign o_wb_cyc  = (state == FETCH_LO) || (state == FETCH_HI);

endmodule

// File: tb/tb_serv_fetch_align.sv
// Bench for serv_fetch_align: directed and random fetches against a sparse
// memory model that predicts instruction, bus word sequence and latency.
module tb_serv_fetch_align;

`ifdef FETCH_HWBUF_EN
  localparam bit HWBUF = 1'b1;
`else
  localparam bit HWBUF = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, cpu_cyc = 1'b0, wb_ack = 1'b0;
  logic [31:0] cpu_adr = '0, wb_rdt = '0;
  logic [31:0] cpu_rdt, wb_adr;
  logic        cpu_ack, wb_cyc;

  always #5 clk = ~clk;

  serv_fetch_align #(.ADDR_W(32)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (flush),
    .i_cpu_adr (cpu_adr),
    .i_cpu_cyc (cpu_cyc),
    .o_cpu_rdt (cpu_rdt),
    .o_cpu_ack (cpu_ack),
    .o_wb_adr  (wb_adr),
    .o_wb_cyc  (wb_cyc),
    .i_wb_rdt  (wb_rdt),
    .i_wb_ack  (wb_ack)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem [logic [29:0]];
  // Model of which word's upper half the fetcher should still remember.
  bit          mv    = 1'b0;
  logic [29:0] mtag  = '0;
  logic [15:0] mdata = '0;

  function automatic logic [31:0] memrd(input logic [29:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    mv    = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input int wmin, input int wmax);
    logic [29:0] w, eq[$], got[$];
    logic [31:0] t0, t1, exp_rdt;
    logic [15:0] h0, h1;
    int          exp_lat, lat, wcnt, wtgt;
    bit          in_acc, acked;
    logic [31:0] acc_adr;
    w  = pc[31:2];
    t0 = memrd(w);
    t1 = memrd(w + 30'd1);
    if (!pc[1]) begin h0 = t0[15:0];  h1 = t0[31:16]; end
    else        begin h0 = t0[31:16]; h1 = t1[15:0];  end
    exp_rdt = (h0[1:0] == 2'b11) ? {h1, h0} : {16'h0, h0};
    // Bus words the fetch must touch, given what the buffer remembers.
    if (!pc[1]) eq.push_back(w);
    else if (mv && mtag == w) begin
      if (mdata[1:0] == 2'b11) eq.push_back(w + 30'd1);
    end else begin
      eq.push_back(w);
      if (h0[1:0] == 2'b11) eq.push_back(w + 30'd1);
    end
    if (eq.size() > 0) begin
      mv    = HWBUF;
      mtag  = eq[eq.size()-1];
      t0    = memrd(mtag);
      mdata = t0[31:16];
    end

    cpu_adr = pc;
    cpu_cyc = 1'b1;
    exp_lat = 1;
    lat     = 0;
    in_acc  = 1'b0;
    acked   = 1'b0;
    wcnt    = 0;
    wtgt    = 0;
    acc_adr = '0;
    for (int i = 0; i < 300 && !acked; i++) begin
      tick;
      lat++;
      wb_ack = 1'b0;
      if (cpu_ack) acked = 1'b1;
      else if (wb_cyc) begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          wcnt    = 0;
          wtgt    = $urandom_range(wmax, wmin);
          acc_adr = wb_adr;
          exp_lat += wtgt + 1;
        end
        if (wcnt == wtgt) begin
          check("wb_adr_stable", wb_adr, acc_adr);
          check("wb_adr_align", {30'h0, wb_adr[1:0]}, 32'h0);
          wb_ack = 1'b1;
          wb_rdt = memrd(wb_adr[31:2]);
          got.push_back(wb_adr[31:2]);
          in_acc = 1'b0;
        end else begin
          wcnt++;
          wb_rdt = $urandom;
        end
      end
    end
    cpu_cyc = 1'b0;
    check("ack_seen", {31'h0, acked}, 32'h1);
    if (acked) begin
      check("rdt", cpu_rdt, exp_rdt);
      check("latency", lat, exp_lat);
      check("bus_count", got.size(), eq.size());
      for (int k = 0; k < eq.size() && k < got.size(); k++)
        check("bus_word", {2'b0, got[k]}, {2'b0, eq[k]});
    end
    tick;
    check("ack_pulse", {31'h0, cpu_ack}, 32'h0);
    check("rdt_hold", cpu_rdt, exp_rdt);
  endtask

  initial begin
    bit reached, stray;

    // Reset state
    tick;
    check("rst_wb_cyc",  {31'h0, wb_cyc},  32'h0);
    check("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    check("rst_cpu_rdt", cpu_rdt, 32'h0);
    check("rst_wb_adr",  wb_adr,  32'h0);
    rst_n = 1'b1;
    tick;

    // Aligned 32-bit with three wait states
    mem[30'h40] = 32'h00A0_0093;
    fetch(32'h0000_0100, 3, 3);

    // Aligned compressed, then the upper half of the same word
    mem[30'h80] = 32'h4505_4501;
    fetch(32'h0000_0200, 0, 2);
    fetch(32'h0000_0202, 0, 2);

    // Straddle across 0x300/0x304, then continue into the buffered word
    mem[30'hC0] = 32'h0093_1234;
    mem[30'hC1] = 32'hBEEF_00A0;
    fetch(32'h0000_0302, 1, 2);
    fetch(32'h0000_0306, 0, 1);

    // Flush forces a refetch of the buffered word
    fetch(32'h0000_0200, 0, 1);
    do_flush;
    fetch(32'h0000_0202, 0, 1);

    // Straddle at the top of the address space wraps to word 0
    mem[30'h3FFF_FFFF] = 32'h0013_5555;
    mem[30'h0]         = 32'hABCD_0001;
    fetch(32'hFFFF_FFFE, 0, 1);

    // Random PCs in a small window so buffer hits and misses mix
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7, 0) == 0) do_flush;
      fetch({22'h0, 4'h4, $urandom_range(31, 0) * 2}, 0, 3);
    end

    // Reset while the second half of a straddle is on the bus
    do_flush;
    mem[30'h140] = 32'hFFFF_0000;
    cpu_adr = 32'h0000_0502;
    cpu_cyc = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      tick;
      wb_ack = 1'b0;
      if (wb_cyc && wb_adr == 32'h0000_0504) reached = 1'b1;
      else if (wb_cyc && wb_adr == 32'h0000_0500) begin
        wb_ack = 1'b1;
        wb_rdt = mem[30'h140];
      end
    end
    check("reach_fetch_hi", {31'h0, reached}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_wb_cyc",  {31'h0, wb_cyc},  32'h0);
    check("midrst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    check("midrst_wb_adr",  wb_adr,  32'h0);
    check("midrst_cpu_rdt", cpu_rdt, 32'h0);
    cpu_cyc = 1'b0;
    mv      = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    wb_ack = 1'b1;
    tick;
    wb_ack = 1'b0;
    stray  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ack || wb_cyc) stray = 1'b1;
      tick;
    end
    check("stray_ack_ignored", {31'h0, stray}, 32'h0);

    // Normal operation resumes after the abandoned cycle
    fetch(32'h0000_0502, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
